// File: rtl/bus_arbiter_pkg.sv
// bus_arb_pkg: shared owner encoding and default bus widths for the RAM port arbiter
package bus_arb_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: CPU, DMA and RAM-side signals of the shared memory port
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: cycle-by-cycle CPU/DMA arbitration of one sync RAM port; BUS_ARBITER_ROUND_ROBIN_EN selects round-robin instead of DMA priority with burst limit
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W        = BUS_ADDR_W,
  parameter int DATA_W        = BUS_DATA_W,
  parameter int DMA_MAX_BURST = 4
) (
  input logic         clk,
  input logic         resetn,
  bus_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE = OWN_NONE;
  localparam logic [1:0] ST_CPU  = OWN_CPU;
  localparam logic [1:0] ST_DMA  = OWN_DMA;

  logic [1:0]        state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  owner_t            tag1_q, tag1_d, tag2_q;
  logic              cpu_win, cpu_gnt, dma_gnt, cpu_rv, dma_rv;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  owner_t last_q, last_d;
  assign cpu_win = last_q == OWN_DMA;
  // remember the most recent winner so the other side gets the next contested cycle
  always_comb begin
    last_d = cpu_gnt ? OWN_CPU : dma_gnt ? OWN_DMA : last_q;
  end
  // reset as if the CPU won last, so DMA takes the first contested cycle
  always_ff @(posedge clk) begin
    if (!resetn) last_q <= OWN_CPU;
    else last_q <= last_d;
  end
`else
  localparam logic [3:0] MAX_B = 4'(DMA_MAX_BURST);
  logic [3:0] burst_cnt_q, burst_cnt_d;
  assign cpu_win = burst_cnt_q == MAX_B;
  // count consecutive DMA grants, saturating; any non-DMA cycle restarts the run
  always_comb begin
    burst_cnt_d = !dma_gnt ? 4'd0 : cpu_win ? MAX_B : burst_cnt_q + 4'd1;
  end
  // burst counter register
  always_ff @(posedge clk) begin
    if (!resetn) burst_cnt_q <= 4'd0;
    else burst_cnt_q <= burst_cnt_d;
  end
`endif

  assign cpu_gnt = resetn & bus.cpu_req & (!bus.dma_req | cpu_win);
  assign dma_gnt = resetn & bus.dma_req & !(bus.cpu_req & cpu_win);

  // winner's access goes to the RAM next cycle; reads launch an owner tag down the return pipe
  always_comb begin
    state_d     = cpu_gnt ? ST_CPU : dma_gnt ? ST_DMA : ST_IDLE;
    mem_en_d    = cpu_gnt | dma_gnt;
    mem_we_d    = cpu_gnt ? bus.cpu_we : dma_gnt & bus.dma_we;
    mem_addr_d  = cpu_gnt ? bus.cpu_addr : dma_gnt ? bus.dma_addr : mem_addr_q;
    mem_wdata_d = cpu_gnt ? bus.cpu_wdata : dma_gnt ? bus.dma_wdata : mem_wdata_q;
    tag1_d      = (mem_en_d & !mem_we_d) ? owner_t'(state_d) : OWN_NONE;
  end

  // registered RAM controls, FSM state and two-stage read owner tag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag1_q      <= OWN_NONE;
      tag2_q      <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
    end
  end

  assign cpu_rv = resetn & (tag2_q == OWN_CPU);
  assign dma_rv = resetn & (tag2_q == OWN_DMA);

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.dma_rvalid = dma_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = dma_rv ? bus.mem_rdata : '0;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of grants, RAM controls, read return and reset for bus_arbiter
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  logic       pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  ram [0:65535];
  logic [7:0]  rd_q = '0;

  always #5 clk = ~clk;

  bus_arbiter_if bus ();
  bus_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rd_q <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 8'h00;
  end
  assign bus.mem_rdata = rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic idle_bus();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    logic [11:0] pat;
    idle_bus();
    bus.cpu_req = 1; bus.dma_req = 1;
    step();
    @(negedge clk);
    check("rst_cpu_gnt", bus.cpu_gnt, 0);
    check("rst_dma_gnt", bus.dma_gnt, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_state", dut.state_q, 0);
    idle_bus();
    step();
    preload(16'hFFFC, 8'h34);
    preload(16'h0300, 8'h77);
    preload(16'h8000, 8'h11);
    preload(16'h8001, 8'h22);
    preload(16'h8002, 8'h33);
    resetn = 1'b1;
    step();

    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'hFFFC;
    @(negedge clk);
    check("rd_cpu_gnt", bus.cpu_gnt, 1);
    check("rd_dma_gnt", bus.dma_gnt, 0);
    step();
    bus.cpu_req = 0;
    @(negedge clk);
    check("rd_mem_en", bus.mem_en, 1);
    check("rd_mem_we", bus.mem_we, 0);
    check("rd_mem_addr", bus.mem_addr, 16'hFFFC);
    check("rd_state", dut.state_q, 1);
    check("rd_rvalid_early", bus.cpu_rvalid, 0);
    step();
    @(negedge clk);
    check("rd_rvalid", bus.cpu_rvalid, 1);
    check("rd_rdata", bus.cpu_rdata, 8'h34);
    check("rd_dma_rvalid", bus.dma_rvalid, 0);
    check("rd_mem_en_off", bus.mem_en, 0);
    check("rd_mem_addr_hold", bus.mem_addr, 16'hFFFC);
    step();
    @(negedge clk);
    check("rd_rvalid_once", bus.cpu_rvalid, 0);
    step();

    do_reset();
    step();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    pat = 12'b010101010101;
`else
    pat = 12'b110111101111;
`endif
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h1000;
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h2000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("pat_dma_%0d", i), bus.dma_gnt, pat[i]);
      check($sformatf("pat_cpu_%0d", i), bus.cpu_gnt, !pat[i]);
      step();
    end
    idle_bus();
    step();
    step();

    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0200; bus.dma_wdata = 8'hA5;
    @(negedge clk);
    check("wr_dma_gnt", bus.dma_gnt, 1);
    step();
    bus.dma_req = 0; bus.dma_we = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0200;
    @(negedge clk);
    check("wr_cpu_gnt", bus.cpu_gnt, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 16'h0200);
    check("wr_mem_wdata", bus.mem_wdata, 8'hA5);
    step();
    bus.cpu_req = 0;
    @(negedge clk);
    check("wr_mem_we_once", bus.mem_we, 0);
    check("wr_mem_en_rd", bus.mem_en, 1);
    check("wr_no_dma_rvalid", bus.dma_rvalid, 0);
    step();
    @(negedge clk);
    check("wr_cpu_rvalid", bus.cpu_rvalid, 1);
    check("wr_cpu_rdata", bus.cpu_rdata, 8'hA5);
    check("wr_dma_rvalid", bus.dma_rvalid, 0);
    step();

    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0300;
    @(negedge clk);
    check("rr_dma_gnt", bus.dma_gnt, 1);
    step();
    bus.dma_req = 0;
    resetn = 1'b0;
    step();
    @(negedge clk);
    check("mid_dma_rvalid", bus.dma_rvalid, 0);
    check("mid_mem_en", bus.mem_en, 0);
    check("mid_mem_addr", bus.mem_addr, 0);
    check("mid_state", dut.state_q, 0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check($sformatf("mid_post_rvalid_%0d", i), bus.dma_rvalid, 0);
    end
    step();

    for (int i = 0; i < 6; i++) begin
      bus.cpu_req = i < 3; bus.cpu_we = 0; bus.cpu_addr = 16'h8000 + 16'(i);
      @(negedge clk);
      check($sformatf("b2b_gnt_%0d", i), bus.cpu_gnt, i < 3);
      check($sformatf("b2b_en_%0d", i), bus.mem_en, i >= 1 && i <= 3);
      if (i >= 1 && i <= 3) check($sformatf("b2b_addr_%0d", i), bus.mem_addr, 16'h8000 + 16'(i - 1));
      check($sformatf("b2b_rv_%0d", i), bus.cpu_rvalid, i >= 2 && i <= 4);
      if (i == 2) check("b2b_d0", bus.cpu_rdata, 8'h11);
      if (i == 3) check("b2b_d1", bus.cpu_rdata, 8'h22);
      if (i == 4) check("b2b_d2", bus.cpu_rdata, 8'h33);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
